// File: rtl/leb128_u32_stream_dec.sv
// Streaming unsigned 32-bit LEB128 decoder: one byte in per cycle, one registered value out.
// Optional malformed-value detection and resync is enabled by defining LEB128_U32_CHECK_EN.
module leb128_u32_stream_dec (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    output logic        i_ready,
    output logic [31:0] o_data,
    output logic [2:0]  o_len,
    output logic        o_err,
    output logic        o_valid,
    input  logic        o_ready
);

`ifdef LEB128_U32_CHECK_EN
    typedef enum logic {S_COLLECT, S_SKIP} state_t;
`else
    typedef enum logic {S_COLLECT} state_t;
`endif

    state_t      state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic [27:0] acc, acc_n;
    logic [31:0] od_n;
    logic [2:0]  ol_n;
    logic        ov_n;
    logic        take, last;
    logic [4:0]  sh;
    logic [31:0] merged;

    // A drained output slot frees the input in the same cycle.
    assign i_ready = !reset && !(o_valid && !o_ready);
    assign take    = i_valid && i_ready;
    assign last    = !i_data[7] || (cnt == 3'd4);
    assign sh      = 5'(cnt) * 5'd7;
    // The 5th chunk shifted by 28 keeps only its low 4 bits.
    assign merged  = {4'b0, acc} | ({25'b0, i_data[6:0]} << sh);

`ifdef LEB128_U32_CHECK_EN
    logic oe_n;
    always_ff @(posedge clk) begin
        if (reset) o_err <= 1'b0;
        else       o_err <= oe_n;
    end
`else
    assign o_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_COLLECT;
            cnt     <= 3'd0;
            acc     <= 28'd0;
            o_data  <= 32'd0;
            o_len   <= 3'd0;
            o_valid <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            acc     <= acc_n;
            o_data  <= od_n;
            o_len   <= ol_n;
            o_valid <= ov_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acc_n   = acc;
        od_n    = o_data;
        ol_n    = o_len;
        ov_n    = o_valid && !o_ready;
`ifdef LEB128_U32_CHECK_EN
        oe_n    = o_err;
`endif
        if (take) begin
            case (state)
                S_COLLECT: begin
                    if (last) begin
                        od_n  = merged;
                        ol_n  = cnt + 3'd1;
                        ov_n  = 1'b1;
                        cnt_n = 3'd0;
                        acc_n = 28'd0;
`ifdef LEB128_U32_CHECK_EN
                        oe_n  = (cnt == 3'd4) && (i_data[7] || (i_data[6:4] != 3'd0));
                        // Value overran 5 bytes: emit it now, then drop its tail.
                        if ((cnt == 3'd4) && i_data[7]) state_n = S_SKIP;
`endif
                    end else begin
                        cnt_n = cnt + 3'd1;
                        acc_n = merged[27:0];
                    end
                end
`ifdef LEB128_U32_CHECK_EN
                S_SKIP: begin
                    if (!i_data[7]) state_n = S_COLLECT;
                end
`endif
                default: state_n = S_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_leb128_u32_stream_dec.sv
// Randomized self-checking bench for leb128_u32_stream_dec with a byte-list LEB128 reference model.
module tb_leb128_u32_stream_dec;

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  l;
        logic        e;
    } out_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  i_data = 8'd0;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [31:0] o_data;
    logic [2:0]  o_len;
    logic        o_err;
    logic        o_valid;
    logic        o_ready;
    logic        ordy_man = 1'b1;
    logic        ordy_rnd = 1'b1;
    logic        rnd_ordy = 1'b0;

    assign o_ready = rnd_ordy ? ordy_rnd : ordy_man;

    leb128_u32_stream_dec dut (
        .clk(clk), .reset(reset),
        .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
        .o_data(o_data), .o_len(o_len), .o_err(o_err),
        .o_valid(o_valid), .o_ready(o_ready)
    );

    always #5 clk = ~clk;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    out_t q[$];
    out_t log_q[$];
    logic [7:0] part[$];
    bit   skip = 0;
    bit   took = 0;

`ifdef LEB128_U32_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference: gather bytes of one value, then decode by summing chunk*128^k.
    task automatic model_byte(input logic [7:0] b);
        longint unsigned v;
        out_t o;
        if (skip) begin
            if (!b[7]) skip = 0;
        end else begin
            part.push_back(b);
            if (!b[7] || part.size() == 5) begin
                v = 0;
                for (int k = 0; k < part.size(); k++)
                    v = v + longint'(part[k][6:0]) * (longint'(1) << (7 * k));
                o.d = v[31:0];
                o.l = 3'(part.size());
                o.e = CHECK && part.size() == 5 && (b[7] || b[6:4] != 3'd0);
                q.push_back(o);
                if (CHECK && part.size() == 5 && b[7]) skip = 1;
                part.delete();
            end
        end
    endtask

    always @(negedge clk) begin
        took = 0;
        if (reset) begin
            chk("rst_i_ready", {31'd0, i_ready}, 32'd0);
            q.delete();
            part.delete();
            skip = 0;
        end else begin
            chk("o_valid", {31'd0, o_valid}, {31'd0, q.size() != 0});
            chk("i_ready", {31'd0, i_ready}, {31'd0, !(q.size() != 0 && !o_ready)});
            if (o_valid && q.size() != 0) begin
                chk("o_data", o_data, q[0].d);
                chk("o_len", {29'd0, o_len}, {29'd0, q[0].l});
                chk("o_err", {31'd0, o_err}, {31'd0, q[0].e});
            end
            if (o_valid && o_ready) begin
                log_q.push_back({o_data, o_len, o_err});
                if (q.size() != 0) void'(q.pop_front());
            end
            if (i_valid && i_ready) begin
                took = 1;
                model_byte(i_data);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        ordy_rnd = ($urandom_range(0, 3) != 0);
    end

    task automatic wait_take();
        int n = 0;
        forever begin
            @(posedge clk);
            if (took) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_data = b;
        i_valid = 1'b1;
        wait_take();
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
    endtask

    task automatic chk_entry(input string nm, input int idx, input out_t e);
        if (idx < log_q.size()) begin
            chk({nm, "_data"}, log_q[idx].d, e.d);
            chk({nm, "_len"}, {29'd0, log_q[idx].l}, {29'd0, e.l});
            chk({nm, "_err"}, {31'd0, log_q[idx].e}, {31'd0, e.e});
        end else begin
            chk({nm, "_missing"}, log_q.size(), idx + 1);
        end
    endtask

    task automatic chk_count(input string nm, input int n);
        chk({nm, "_count"}, log_q.size(), n);
    endtask

    initial begin
        idle(2);
        chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_o_data", o_data, 32'd0);
        chk("rst_o_len", {29'd0, o_len}, 32'd0);
        chk("rst_o_err", {31'd0, o_err}, 32'd0);
        chk("rst_i_ready_lit", {31'd0, i_ready}, 32'd0);
        reset = 1'b0;
        idle(1);

        log_q.delete();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h7F);
        idle(3);
        chk_count("single", 3);
        chk_entry("single0", 0, {32'h0, 3'd1, 1'b0});
        chk_entry("single1", 1, {32'h1, 3'd1, 1'b0});
        chk_entry("single2", 2, {32'h7F, 3'd1, 1'b0});

        log_q.delete();
        send_byte(8'hE5); send_byte(8'h8E); send_byte(8'h26);
        chk("e5_latency_valid", {31'd0, o_valid}, 32'd1);
        idle(2);
        chk_entry("e58e26", 0, {32'h00098765, 3'd3, 1'b0});

        log_q.delete();
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h0F);
        idle(2);
        chk_entry("max", 0, {32'hFFFFFFFF, 3'd5, 1'b0});

        log_q.delete();
        ordy_man = 1'b0;
        send_byte(8'h05);
        i_data = 8'h06;
        i_valid = 1'b1;
        idle(3);
        chk("bp_i_ready", {31'd0, i_ready}, 32'd0);
        chk("bp_hold", o_data, 32'd5);
        ordy_man = 1'b1;
        wait_take();
        i_valid = 1'b0;
        chk("bp_next", o_data, 32'd6);
        idle(2);
        chk_count("bp", 2);
        chk_entry("bp0", 0, {32'd5, 3'd1, 1'b0});
        chk_entry("bp1", 1, {32'd6, 3'd1, 1'b0});

        log_q.delete();
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h7F);
        idle(2);
        chk_entry("over7f", 0, {32'hFFFFFFFF, 3'd5, CHECK});

        log_q.delete();
        for (int k = 0; k < 5; k++) send_byte(8'hFF);
        send_byte(8'h80); send_byte(8'h01); send_byte(8'h02);
        idle(2);
        if (CHECK) begin
            chk_count("skip", 2);
            chk_entry("skip0", 0, {32'hFFFFFFFF, 3'd5, 1'b1});
            chk_entry("skip1", 1, {32'd2, 3'd1, 1'b0});
        end else begin
            chk_count("noskip", 3);
            chk_entry("noskip0", 0, {32'hFFFFFFFF, 3'd5, 1'b0});
            chk_entry("noskip1", 1, {32'h80, 3'd2, 1'b0});
            chk_entry("noskip2", 2, {32'd2, 3'd1, 1'b0});
        end

        log_q.delete();
        send_byte(8'hE5);
        pulse_reset();
        send_byte(8'h05);
        idle(2);
        chk_count("midrst", 1);
        chk_entry("midrst0", 0, {32'd5, 3'd1, 1'b0});

        rnd_ordy = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] b;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            if (i % 700 == 350) pulse_reset();
            b = 8'($urandom);
            b[7] = ($urandom_range(0, 1) == 1);
            send_byte(b);
        end
        rnd_ordy = 1'b0;
        ordy_man = 1'b1;
        idle(5);
        chk("drain_empty", q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/leb128_u32_stream_dec.md
Name: leb128_u32_stream_dec

Overview:
- Streaming controller for unsigned 32-bit LEB128 decoding.
- Accepts one encoded byte per cycle over a valid/ready input stream.
- Collects up to 5 bytes per value, decodes them, and presents one 32-bit value plus its byte length on a registered valid/ready output.
- Sits between a byte-wide transport (file/section reader) and consumers of decoded integers.

Parameters:
- none (format fixed at u32, max 5 bytes)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_data  in  8  encoded byte; bit 7 = continuation, bits 6:0 = chunk
- i_valid  in  1  i_data valid
- i_ready  out  1  block accepts i_data this cycle
- o_data  out  32  decoded value
- o_len  out  3  bytes consumed by this value, 1..5
- o_err  out  1  value malformed (see Optional Feature); 0 when feature is off
- o_valid  out  1  o_data/o_len/o_err valid
- o_ready  in  1  consumer accepts output

Behaviour:
- Reset: decoder in COLLECT, byte count 0, accumulator 0. Outputs: o_valid=0, o_data=0, o_len=0, o_err=0, i_ready=0 during the reset cycle.
- Accumulator: byte k (k = 0..4) contributes chunk<<(7k). Byte 4 contributes only bits 3:0; bits 6:4 are dropped from o_data.
- Accept condition: i_valid && i_ready. No byte is consumed otherwise.
- i_ready = !reset && !(o_valid && !o_ready).
  - Output register is full and stalled: input stalls.
  - Output drains in the same cycle: input is accepted (full throughput).
- State COLLECT, on each accepted byte:
  - Terminal byte (bit7=0) or count==4: load o_data with the accumulator merged with this byte, o_len=count+1, o_valid=1 next cycle. Clear count and accumulator; stay in COLLECT.
  - Otherwise: count++ and merge the chunk.
- Latency: o_valid rises on the cycle after the terminal byte is accepted.
- Sustained rate: one single-byte value per cycle.
- Output hold: o_valid, once set, holds with stable o_data/o_len/o_err until o_valid && o_ready. It clears that cycle unless a new terminal byte is accepted in the same cycle, in which case it reloads.
- State SKIP exists only with the feature enabled (see below).
- Reset mid-sequence: partial accumulation is discarded, any pending output is dropped, o_valid=0.
- No timeout: a partial value waits indefinitely for further bytes.

Optional Feature:
- Macro: LEB128_U32_CHECK_EN.
- Defined:
  - The 5th byte (count==4) sets o_err=1 on the emitted value if bit7=1 or bits 6:4 != 0. o_data is still the truncated 32-bit value and o_len=5.
  - If that 5th byte has bit7=1, the FSM enters SKIP.
  - SKIP: i_ready follows the same rule, but accepted bytes are discarded with no output. The first accepted byte with bit7=0 is discarded, then the FSM returns to COLLECT.
  - The errored value is emitted on entry to SKIP, not at its end.
- Undefined:
  - The 5th byte always terminates the value.
  - Excess bits are silently dropped.
  - o_err is tied to 0; there is no SKIP state.

Test Plan:
- 00 with o_ready=1 → one cycle later o_data=0x00000000, o_len=1, o_err=0; back-to-back 01,7F → outputs 1 then 127 on consecutive cycles.
- E5 8E 26 → o_data=624485 (0x00098765), o_len=3, o_valid exactly one cycle after 0x26 is accepted.
- FF FF FF FF 0F → o_data=0xFFFFFFFF, o_len=5, o_err=0.
- Backpressure: o_ready=0; send 05, then 06 → first output holds 5; i_ready=0 so 06 is not accepted. Raise o_ready → 5 drains, 06 is accepted that cycle, then o_data=6.
- With LEB128_U32_CHECK_EN: FF FF FF FF 7F → o_data=0xFFFFFFFF, o_len=5, o_err=1. FF FF FF FF FF 80 01 02 → one errored output, 80 and 01 skipped, then o_data=2, o_err=0. Without the macro, the second sequence yields 0xFFFFFFFF (len 5), then 0x80 (len 2, from 80 01), then 2.
- Reset mid-value: E5 accepted, reset pulsed 1 cycle, then 05 → single output o_data=5, o_len=1; no output for the partial E5.
